// File: rtl/syndrome_stream_packer_if.sv
// Handshake bundle for the syndrome packer: round input stream plus
// the byte-wide stream toward the decoder.
interface syndrome_stream_packer_if #(
    parameter int MEAS_WIDTH = 4
);
    logic [MEAS_WIDTH-1:0] meas_data;
    logic                  meas_valid;
    logic                  meas_ready;
    logic [7:0]            output_data;
    logic                  output_valid;
    logic                  output_ready;
    logic                  block_done;

    // Environment side: produces rounds, consumes bytes.
    modport master (
        output meas_data, meas_valid, output_ready,
        input  meas_ready, output_data, output_valid, block_done
    );

    // Packer side.
    modport slave (
        input  meas_data, meas_valid, output_ready,
        output meas_ready, output_data, output_valid, block_done
    );
endinterface

// File: rtl/syndrome_stream_packer.sv
// Buffers parallel syndrome rounds and serialises each block of
// GRID_WIDTH_U rounds as: header byte, then round bytes in round order.
module syndrome_stream_packer #(
    parameter int          GRID_WIDTH_X = 4,
    parameter int          GRID_WIDTH_Z = 1,
    parameter int          GRID_WIDTH_U = 3,
    parameter int          FIFO_DEPTH   = 2,
    parameter logic [7:0]  START_HEADER = 8'hFF
) (
    input logic                     clk,
    input logic                     reset,
    syndrome_stream_packer_if.slave bus
);
    localparam int MEAS_WIDTH      = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int BYTES_PER_ROUND = (MEAS_WIDTH + 7) / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = (GRID_WIDTH_U > 1) ? $clog2(GRID_WIDTH_U) : 1;
    localparam int BW = (BYTES_PER_ROUND > 1) ? $clog2(BYTES_PER_ROUND) : 1;

    localparam logic [PW:0]   CNT_FULL   = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);
    localparam logic [RW-1:0] ROUND_LAST = RW'(GRID_WIDTH_U - 1);
    localparam logic [BW-1:0] BYTE_LAST  = BW'(BYTES_PER_ROUND - 1);

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD} state_t;

    logic [MEAS_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic                  fifo_full, fifo_empty;
    logic                  meas_ready, push, pop;

    state_t                state_q, state_d;
    logic [RW-1:0]         round_q, round_d;
    logic [BW-1:0]         byte_q, byte_d;
    logic [8*BYTES_PER_ROUND-1:0] head_pad;
    logic                  out_valid, done;
    logic [7:0]            out_data;

    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);
    // Gated by reset so the source sees no space while the packer is held.
    assign meas_ready = reset && !fifo_full;
    assign push       = bus.meas_valid && meas_ready;

    assign bus.meas_ready   = meas_ready;
    assign bus.output_valid = out_valid;
    assign bus.output_data  = out_data;
    assign bus.block_done   = done;

    // Round storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.meas_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Framing state and position counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            round_q <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            byte_q  <= byte_d;
        end
    end

    // Next state and stream outputs; output valid/data come from registers only.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        byte_d    = byte_q;
        pop       = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        head_pad  = '0;
        head_pad[MEAS_WIDTH-1:0] = mem[rd_ptr];
        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = HEADER;
            end
            HEADER: begin
                out_valid = 1'b1;
                out_data  = START_HEADER;
                if (bus.output_ready) begin
                    state_d = PAYLOAD;
                    byte_d  = '0;
                end
            end
            PAYLOAD: begin
                out_valid = !fifo_empty;
                out_data  = head_pad[8*byte_q +: 8];
                if (out_valid && bus.output_ready) begin
                    if (byte_q != BYTE_LAST) begin
                        byte_d = byte_q + BW'(1);
                    end else begin
                        pop    = 1'b1;
                        byte_d = '0;
                        if (round_q == ROUND_LAST) begin
                            round_d = '0;
                            done    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            round_d = round_q + RW'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/syndrome_stream_packer.md
Name: syndrome_stream_packer

Overview:
- Upstream feeder for the single-FPGA Helios decoder top.
- Accepts one measurement round per handshake, as a parallel vector of GRID_WIDTH_X*GRID_WIDTH_Z syndrome bits.
- Buffers rounds in a small FIFO and serialises each block of GRID_WIDTH_U rounds onto the decoder's 8-bit valid/ready input stream.
- Wire format per block: one header byte, then the round payload bytes in round order.

Parameters:
- GRID_WIDTH_X, 4, decoding-graph X width.
- GRID_WIDTH_Z, 1, decoding-graph Z width.
- GRID_WIDTH_U, 3, rounds per decode block.
- FIFO_DEPTH, 2, round-buffer depth; power of two, ≥2.
- START_HEADER, 8'hFF, byte emitted at the start of every block.
- Derived: MEAS_WIDTH = GRID_WIDTH_X*GRID_WIDTH_Z.
- Derived: BYTES_PER_ROUND = ceil(MEAS_WIDTH/8).

Ports:
- clk  in  1  single clock.
- reset  in  1  one clock; reset is asynchronous and active-low.
- meas_data  in  MEAS_WIDTH  one round of syndrome bits; bit i = PU i of the round.
- meas_valid  in  1  meas_data valid.
- meas_ready  out  1  packer can accept a round.
- output_data  out  8  byte to decoder input_data.
- output_valid  out  1  output_data valid.
- output_ready  in  1  decoder accepts byte.
- block_done  out  1  one-cycle pulse on acceptance of the final byte of a block.

Behaviour:
- Reset (reset=0, async) clears the following; takes effect immediately and holds until release:
  - FIFO empty; state IDLE; round_cnt=0; byte_idx=0.
  - meas_ready=0 while in reset.
  - output_valid=0, output_data=0, block_done=0.
- Input handshake:
  - Push occurs when meas_valid & meas_ready.
  - meas_ready = !fifo_full, registered-derived only.
  - No push-through when full: a pop in the same cycle does not raise meas_ready that cycle.
- Output handshake:
  - Transfer occurs when output_valid & output_ready.
  - Once output_valid=1, output_data and output_valid hold until the transfer.
  - output_valid/output_data depend on registers only; no combinational path from meas_valid or output_ready.
- FSM:
  - IDLE: output_valid=0. If FIFO non-empty → HEADER.
  - HEADER: output_valid=1, output_data=START_HEADER. On transfer → PAYLOAD, byte_idx=0.
  - PAYLOAD:
    - output_valid = !fifo_empty.
    - output_data = bits [8*byte_idx+7 : 8*byte_idx] of the FIFO head, upper bits beyond MEAS_WIDTH zero-padded.
    - On transfer with byte_idx<BYTES_PER_ROUND-1: byte_idx++.
    - On transfer of the last byte: pop head, byte_idx=0.
    - If round_cnt==GRID_WIDTH_U-1: round_cnt=0, block_done=1 for that cycle, → IDLE. Else round_cnt++, stay in PAYLOAD.
- Latency:
  - Round pushed at cycle t into empty packer in IDLE → HEADER valid at t+2 (FIFO write t, IDLE→HEADER t+1, visible t+2).
  - Full throughput: 1 byte/cycle sustained when FIFO is kept non-empty and output_ready=1.
- Headers: not popped from FIFO; header emission does not consume a round.
- Simultaneous push and pop: both occur; count unchanged.
- FIFO pointers: wrap modulo FIFO_DEPTH.
- Counter widths:
  - round_cnt: $clog2(GRID_WIDTH_U), min 1.
  - byte_idx: $clog2(BYTES_PER_ROUND), min 1.
- Reset mid-block: partial block discarded; downstream decoder must be reset together.
- meas_data while meas_valid=0 is ignored.

Test Plan:
- Defaults, output_ready=1, push 4'hA, 4'h5, 4'hF back-to-back -> bytes FF,0A,05,0F on consecutive transfer cycles. block_done pulses exactly once, with 0F.
- Defaults, push 4'h3, hold output_ready=0 for 5 cycles after output_valid rises -> output_data=FF and output_valid=1 stable all 5 cycles. FF transfers on cycle ready returns, then 03.
- Defaults, output_ready=0, present 3 rounds continuously -> exactly 2 accepted, meas_ready=0 afterwards. Raising output_ready drains FF, r0, r1 and accepts the third round on the cycle after r0 pops.
- GRID_WIDTH_X=11, round 11'h5A3 plus two more -> per-round bytes A3 then 05 (upper 5 bits zero). Block length 7 bytes.
- Defaults, 6 rounds 1..6, output_ready=1 -> FF,01,02,03,FF,04,05,06. Two block_done pulses.
- Assert reset after FF and 01 transferred -> output_valid=0, meas_ready=0 during reset. After release, a new round yields FF first; old rounds are never emitted.
